data_processing_pipe: RTL and testbench
=======================================

DATA_PROCESSING_PIPE -- requirements
Module: data_processing_pipe

Interface
REQ-001 Parameter DATA_W, default 8: data path width in bits; legal range 4..32.
REQ-002 Parameter DEPTH, default 4: output buffer depth in beats; power of two, at least 2.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 valid_in  input  1  upstream beat valid.
REQ-006 ready_in  output  1  block can accept a beat this cycle.
REQ-007 data_in  input  DATA_W  upstream data.
REQ-008 mode  input  3  operation select, sampled with each accepted beat.
REQ-009 valid_out  output  1  buffer head holds a valid beat.
REQ-010 ready_out  input  1  downstream accepts the head beat.
REQ-011 data_out  output  DATA_W  buffer head data.
REQ-012 level  output  $clog2(DEPTH+1)  number of beats currently buffered.

Function
REQ-013 An input beat SHALL be accepted on a rising edge when valid_in && ready_in; an output beat SHALL be consumed when valid_out && ready_out.
REQ-014 ready_in SHALL be (level < DEPTH) || ready_out, combinationally; no combinational path exists from valid_in to ready_in.
REQ-015 mode 000 SHALL be bypass: result = data_in.
REQ-016 mode 001 SHALL be increment: data_in + 1.
REQ-017 mode 010 SHALL be invert: ~data_in.
REQ-018 mode 011 SHALL be gain x2: data_in << 1.
REQ-019 mode 100 SHALL be halve: logical data_in >> 1.
REQ-020 mode 101 SHALL be decrement: data_in - 1.
REQ-021 mode 110 SHALL be rotate-left by 1: {data_in[DATA_W-2:0], data_in[DATA_W-1]}.
REQ-022 mode 111 SHALL be reserved and behave as bypass.
REQ-023 Every result SHALL be DATA_W bits wide. Carries out of the MSB and borrows SHALL be discarded unless REQ-034 applies.
REQ-024 An accepted beat SHALL be written to the buffer tail at that edge. If the buffer was empty, the beat SHALL appear on data_out with valid_out=1 immediately after that edge (1-cycle latency).
REQ-025 Beats SHALL leave in acceptance order. Each beat's mode SHALL be bound at acceptance, so later mode changes never alter buffered beats.
REQ-026 data_out and valid_out SHALL stay stable while valid_out && !ready_out.
REQ-027 level update per edge:
- push only: level+1
- pop only: level-1
- push and pop together: level unchanged
REQ-028 Full (level==DEPTH) with ready_out=1: a push and a pop SHALL occur on the same edge, and level SHALL stay at DEPTH.
REQ-029 Empty (level==0): valid_out SHALL be 0, and ready_out SHALL have no effect.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH without losing or duplicating a beat.

Reset
REQ-031 While rst=1 at a rising edge, the block SHALL clear:
- valid_out to 0
- level to 0
- both pointers to 0
- data_out to all zeros
REQ-032 Reset asserted mid-stream SHALL discard all buffered beats. ready_in SHALL read 1 on the first cycle after rst deasserts.
REQ-033 No beat SHALL be accepted on an edge where rst=1.

Configuration
REQ-034 Macro DATA_PROCESSING_PIPE_SAT_EN defined: modes 001, 011 and 101 SHALL saturate.
- 001 with all-ones input: result all-ones.
- 011 with MSB set: result all-ones.
- 101 with zero input: result zero.
REQ-035 Macro not defined: modes 001, 011 and 101 SHALL wrap modulo 2^DATA_W. All other modes are identical in both builds.

Verification
REQ-036 DATA_W=8, ready_out=1, data_in=0x3C in modes 000..111 -> data_out = 3C, 3D, C3, 78, 1E, 3B, 78, 3C, one cycle after each accept.
REQ-037 Wrap build: 0xFF in mode 001 -> 0x00; 0x81 in mode 011 -> 0x02; 0x00 in mode 101 -> 0xFF. SAT build, same stimulus -> 0xFF, 0xFF, 0x00.
REQ-038 DEPTH=4, ready_out=0, push 0x01..0x05 -> level reaches 4 and ready_in=0 after the 4th accept. Raising ready_out then drains 01, 02, 03, 04; 05 is accepted only when ready_in returns to 1.
REQ-039 Full buffer, ready_out=1, valid_in=1 for 10 cycles with an incrementing pattern -> level stays 4, one beat per cycle in order, no loss across pointer wrap.
REQ-040 Push 3 beats in mode 001, switch mode to 010 while they are buffered -> the 3 outputs are still incremented values.
REQ-041 Assert rst for 1 cycle with level=3 -> next cycle: level=0, valid_out=0, data_out=0, ready_in=1; a subsequent push of 0x55 in mode 000 -> data_out=0x55 after 1 cycle.

Source files
------------

// File: rtl/data_processing_pipe.sv
// data_processing_pipe: per-beat arithmetic/logic transform feeding an in-order output buffer.
// Define DATA_PROCESSING_PIPE_SAT_EN to make increment, gain x2 and decrement saturate instead of wrap.
module data_processing_pipe #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [2:0]                 mode,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [LW-1:0]     FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]     L_ONE = LW'(1);
    localparam logic [AW-1:0]     P_ONE = AW'(1);
    localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] result;
    logic              push;
    logic              pop;

    // Ready depends only on occupancy and downstream ready, never on valid_in.
    assign ready_in  = (level < FULL) || ready_out;
    assign valid_out = (level != '0);
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;
    assign data_out  = valid_out ? mem[rd_ptr] : '0;

    // Transform the incoming beat; mode is bound here, at acceptance.
    always_comb begin
        result = data_in;
        case (mode)
            3'b000: result = data_in;
`ifdef DATA_PROCESSING_PIPE_SAT_EN
            3'b001: result = (&data_in) ? '1 : data_in + D_ONE;
            3'b011: result = data_in[DATA_W-1] ? '1 : data_in << 1;
            3'b101: result = (data_in == '0) ? '0 : data_in - D_ONE;
`else
            3'b001: result = data_in + D_ONE;
            3'b011: result = data_in << 1;
            3'b101: result = data_in - D_ONE;
`endif
            3'b010: result = ~data_in;
            3'b100: result = data_in >> 1;
            3'b110: result = {data_in[DATA_W-2:0], data_in[DATA_W-1]};
            default: result = data_in;
        endcase
    end

    // Buffer storage: write the transformed beat at the tail.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= result;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + L_ONE;
                2'b01:   level <= level - L_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_data_processing_pipe.sv
// tb_data_processing_pipe: directed vectors with hand-computed expectations.
// Covers transforms, back-pressure, full-buffer streaming, mode binding and reset.
module tb_data_processing_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_in;
    logic [2:0] mode;
    logic       valid_out;
    logic       ready_out;
    logic [7:0] data_out;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;

    data_processing_pipe #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .mode      (mode),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] m);
        data_in  = d;
        mode     = m;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    logic [7:0] exp_36 [8];
    logic [7:0] exp_37 [3];

    initial begin
        exp_36 = '{8'h3C, 8'h3D, 8'hC3, 8'h78, 8'h1E, 8'h3B, 8'h78, 8'h3C};
`ifdef DATA_PROCESSING_PIPE_SAT_EN
        exp_37 = '{8'hFF, 8'hFF, 8'h00};
`else
        exp_37 = '{8'h00, 8'h02, 8'hFF};
`endif
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        mode      = 3'b000;
        ready_out = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_ready", 32'(ready_in), 32'd1);

        // All modes on 0x3C, back-to-back with downstream always ready
        ready_out = 1'b1;
        for (int m = 0; m < 8; m++) begin
            data_in  = 8'h3C;
            mode     = 3'(m);
            valid_in = 1'b1;
            tick();
            check($sformatf("mode%0d_data", m), 32'(data_out), 32'(exp_36[m]));
            check($sformatf("mode%0d_valid", m), 32'(valid_out), 32'd1);
        end
        valid_in = 1'b0;
        tick();
        check("modes_empty", 32'(level), 32'd0);

        // Wrap/saturate boundaries
        push(8'hFF, 3'b001);
        check("inc_ff", 32'(data_out), 32'(exp_37[0]));
        push(8'h81, 3'b011);
        check("gain_81", 32'(data_out), 32'(exp_37[1]));
        push(8'h00, 3'b101);
        check("dec_00", 32'(data_out), 32'(exp_37[2]));
        push(8'h80, 3'b110);
        check("rol_80", 32'(data_out), 32'h01);
        push(8'h81, 3'b100);
        check("half_81", 32'(data_out), 32'h40);
        tick();
        check("bound_empty", 32'(valid_out), 32'd0);

        // Back-pressure: fill, block, then drain
        ready_out = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i), 3'b000);
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(ready_in), 32'd0);
        data_in  = 8'h05;
        mode     = 3'b000;
        valid_in = 1'b1;
        tick();
        check("blocked_level", 32'(level), 32'd4);
        check("blocked_head", 32'(data_out), 32'h01);
        ready_out = 1'b1;
        #1;
        check("unblock_ready", 32'(ready_in), 32'd1);
        check("drain_01", 32'(data_out), 32'h01);
        tick();
        valid_in = 1'b0;
        check("drain_02", 32'(data_out), 32'h02);
        check("drain_lvl4", 32'(level), 32'd4);
        for (int i = 3; i <= 5; i++) begin
            tick();
            check($sformatf("drain_%02h", i), 32'(data_out), 32'(i));
            check($sformatf("drain_lvl_%0d", i), 32'(level), 32'(6 - i));
        end
        tick();
        check("drain_empty", 32'(valid_out), 32'd0);

        // Full buffer streaming across pointer wrap
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 3'b000);
        ready_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in  = 8'(8'h14 + i);
            mode     = 3'b000;
            valid_in = 1'b1;
            #1;
            check($sformatf("stream_%0d", i), 32'(data_out), 32'(8'h10 + i));
            tick();
            check($sformatf("stream_lvl_%0d", i), 32'(level), 32'd4);
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tail_%0d", i), 32'(data_out), 32'(8'h1A + i));
            tick();
        end
        check("stream_empty", 32'(level), 32'd0);

        // Mode is bound at acceptance
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'h20 + i), 3'b001);
        mode      = 3'b010;
        ready_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bind_%0d", i), 32'(data_out), 32'(8'h21 + i));
            tick();
        end

        // Reset mid-stream, with a beat offered during reset
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'hA0 + i), 3'b000);
        check("pre_rst_level", 32'(level), 32'd3);
        rst      = 1'b1;
        data_in  = 8'h77;
        valid_in = 1'b1;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_ready", 32'(ready_in), 32'd1);
        push(8'h55, 3'b000);
        check("post_rst_data", 32'(data_out), 32'h55);
        check("post_rst_valid", 32'(valid_out), 32'd1);
        check("post_rst_level", 32'(level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
